lsu: RTL and testbench

- Multi-cycle load/store unit forming the memory stage between the ALU and writeback.
- Accepts one request (effective address, funct3, store data, rd) from execute, checks alignment, and performs one word-aligned access on a req/gnt/rvalid data bus with byte-enables.
- Returns sign- or zero-extended load data to writeback; raises a one-cycle exception pulse for the trap logic in place of a bus access.

---
 rtl/lsu_pkg.sv | 14 +
 rtl/lsu_align.sv | 32 +++
 rtl/lsu.sv | 126 ++++++++++++
 tb/tb_lsu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, exception cause codes and FSM state type shared by the LSU files
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [3:0] C_ILL = 4'd2;
   localparam logic [3:0] C_LMA = 4'd4;
   localparam logic [3:0] C_LAF = 4'd5;
   localparam logic [3:0] C_SMA = 4'd6;
   localparam logic [3:0] C_SAF = 4'd7;
   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_EXC} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering, misalign/illegal detection and load extraction (combinational)
//   is_store/funct3/off : access kind and byte offset addr[1:0]
//   wdata -> wdata_out  : lane-replicated store data;  be : byte enables
//   rdata -> ldata      : sign/zero-extended load result
module lsu_align
   import lsu_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_out,
   output logic [31:0] ldata,
   output logic        misalign,
   output logic        illegal
);
   logic [1:0]  size;
   logic [15:0] x;
   assign size      = funct3[1:0];
   assign illegal   = is_store ? funct3 > F3_W : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
   assign misalign  = (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
   assign be        = (!is_store || size == 2'b10) ? 4'b1111 :
                      size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
   assign wdata_out = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
   assign x         = 16'(rdata >> {off, 3'b000});
   assign ldata     = funct3 == F3_B  ? {{24{x[7]}}, x[7:0]} :
                      funct3 == F3_BU ? {24'd0, x[7:0]} :
                      funct3 == F3_H  ? {{16{x[15]}}, x} :
                      funct3 == F3_HU ? {16'd0, x} : rdata;
endmodule

// File: rtl/lsu.sv
// lsu: multi-cycle load/store unit between execute and writeback
//   req_*  : request from execute (accepted when req_valid && req_ready)
//   resp_* : one-cycle completion pulse towards writeback
//   exc_*  : one-cycle exception pulse (illegal funct3, misaligned, bus timeout)
//   bus_*  : word-aligned req/gnt/rvalid data bus with byte enables
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   output logic        resp_we,
   output logic [4:0]  resp_rd,
   output logic [31:0] resp_data,
   output logic        exc_valid,
   output logic [3:0]  exc_cause,
   output logic [31:0] exc_addr,
   output logic        busy,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);
   state_t      state, state_n;
   logic        is_store_q, accept, to, misalign, illegal;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, rdata_q, wd, ldata;
   logic [4:0]  rd_q;
   logic [7:0]  cnt;
   logic [3:0]  be, cause_n;
   // req_ready is only ever high in IDLE, so this is the IDLE-accept condition
   assign accept = req_valid && req_ready;
   // in IDLE the aligner judges the incoming request; afterwards it extracts from the latched access
   lsu_align u_align (
      .is_store  (state == S_IDLE ? req_is_store : is_store_q),
      .funct3    (state == S_IDLE ? req_funct3 : f3_q),
      .off       (state == S_IDLE ? req_addr[1:0] : addr_q[1:0]),
      .wdata     (req_wdata),
      .rdata     (rdata_q),
      .be        (be),
      .wdata_out (wd),
      .ldata     (ldata),
      .misalign  (misalign),
      .illegal   (illegal)
   );
   always_comb begin
      state_n = state;
      to      = ({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT);
      cause_n = state == S_IDLE ? (illegal ? C_ILL : req_is_store ? C_SMA : C_LMA) :
                is_store_q ? C_SAF : C_LAF;
      unique case (state)
         S_IDLE:  state_n = accept ? ((illegal || misalign) ? S_EXC : S_REQ) : S_IDLE;
         S_REQ:   state_n = (bus_gnt && bus_rvalid) ? S_DONE : to ? S_EXC : bus_gnt ? S_WAIT : S_REQ;
         S_WAIT:  state_n = bus_rvalid ? S_DONE : to ? S_EXC : S_WAIT;
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 8'd0;
         is_store_q <= 1'b0;
         f3_q       <= 3'd0;
         addr_q     <= 32'd0;
         rdata_q    <= 32'd0;
         rd_q       <= 5'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_we    <= 1'b0;
         resp_rd    <= 5'd0;
         resp_data  <= 32'd0;
         exc_valid  <= 1'b0;
         exc_cause  <= 4'd0;
         exc_addr   <= 32'd0;
         busy       <= 1'b0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= 32'd0;
         bus_be     <= 4'd0;
         bus_wdata  <= 32'd0;
      end else begin
         state      <= state_n;
         cnt        <= (state == S_REQ || state == S_WAIT) ? cnt + 8'd1 : 8'd0;
         // stays low for the IDLE cycle after DONE/EXC, giving the 4-cycle turnaround
         req_ready  <= state == S_IDLE && state_n == S_IDLE;
         busy       <= state_n != S_IDLE;
         bus_req    <= state_n == S_REQ;
         resp_valid <= state == S_DONE;
         resp_we    <= state == S_DONE && !is_store_q && rd_q != 5'd0;
         exc_valid  <= state_n == S_EXC;
         if (accept) begin
            is_store_q <= req_is_store;
            f3_q       <= req_funct3;
            addr_q     <= req_addr;
            rd_q       <= req_rd;
            bus_we     <= req_is_store;
            bus_addr   <= {req_addr[31:2], 2'b00};
            bus_be     <= be;
            bus_wdata  <= wd;
         end
         if (bus_rvalid && (state == S_WAIT || (state == S_REQ && bus_gnt)))
            rdata_q <= bus_rdata;
         if (state == S_DONE) begin
            resp_rd   <= rd_q;
            resp_data <= is_store_q ? 32'd0 : ldata;
         end
         if (state_n == S_EXC) begin
            exc_cause <= cause_n;
            exc_addr  <= state == S_IDLE ? req_addr : addr_q;
         end
      end
   end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench; u_dut uses the default timeout, u_t uses TIMEOUT=4
module tb_lsu;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_valid_t = 1'b0, req_is_store = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, bus_rdata = 32'd0;
   logic [4:0]  req_rd = 5'd0;
   logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, t_gnt = 1'b0, t_rvalid = 1'b0;
   logic        req_ready, resp_valid, resp_we, exc_valid, busy, bus_req, bus_we;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data, exc_addr, bus_addr, bus_wdata;
   logic [3:0]  exc_cause, bus_be;
   logic        t_req_ready, t_resp_valid, t_resp_we, t_exc_valid, t_busy, t_bus_req, t_bus_we;
   logic [4:0]  t_resp_rd;
   logic [31:0] t_resp_data, t_exc_addr, t_bus_addr, t_bus_wdata;
   logic [3:0]  t_exc_cause, t_bus_be;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   lsu u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid), .resp_we(resp_we),
      .resp_rd(resp_rd), .resp_data(resp_data), .exc_valid(exc_valid), .exc_cause(exc_cause),
      .exc_addr(exc_addr), .busy(busy), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   lsu #(.TIMEOUT(4)) u_t (
      .clk(clk), .rst(rst), .req_valid(req_valid_t), .req_ready(t_req_ready),
      .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(t_resp_valid), .resp_we(t_resp_we),
      .resp_rd(t_resp_rd), .resp_data(t_resp_data), .exc_valid(t_exc_valid), .exc_cause(t_exc_cause),
      .exc_addr(t_exc_addr), .busy(t_busy), .bus_req(t_bus_req), .bus_we(t_bus_we),
      .bus_addr(t_bus_addr), .bus_be(t_bus_be), .bus_wdata(t_bus_wdata), .bus_gnt(t_gnt),
      .bus_rvalid(t_rvalid), .bus_rdata(bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // drive a request for one cycle; returns at the negedge of cycle 1 (first REQ/EXC cycle)
   task automatic issue(input bit t, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
      chk("ready_before_issue", t ? t_req_ready : req_ready, 1);
      req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
      if (t) req_valid_t = 1'b1; else req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; req_valid_t = 1'b0;
   endtask

   // gnt and rvalid together in cycle 1; returns at the negedge of cycle 3
   task automatic fast(input logic [31:0] rd);
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = rd;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      chk("bus_req_drop", bus_req, 0);
      chk("resp_not_early", resp_valid, 0);
      @(negedge clk);
   endtask

   task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] rdata, input logic [31:0] exp);
      issue(0, 0, f3, a, 32'd0, 5'd9);
      chk({tag, "_be"}, bus_be, 4'b1111);
      fast(rdata);
      chk({tag, "_valid"}, resp_valid, 1);
      chk({tag, "_data"}, resp_data, exp);
      chk({tag, "_we"}, resp_we, 1);
      @(negedge clk);
      chk({tag, "_ready"}, req_ready, 1);
   endtask

   task automatic exc_case(input string tag, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [3:0] cause);
      issue(0, st, f3, a, 32'h12345678, 5'd4);
      chk({tag, "_exc_valid"}, exc_valid, 1);
      chk({tag, "_cause"}, exc_cause, cause);
      chk({tag, "_addr"}, exc_addr, a);
      chk({tag, "_no_bus"}, bus_req, 0);
      @(negedge clk);
      chk({tag, "_exc_pulse"}, exc_valid, 0);
      chk({tag, "_no_resp"}, resp_valid, 0);
      chk({tag, "_no_bus2"}, bus_req, 0);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_exc_valid", exc_valid, 0);
      chk("rst_bus_be", bus_be, 0);
      // stray bus handshake in IDLE is ignored
      bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      @(negedge clk);
      chk("idle_stray_resp", resp_valid, 0);
      chk("idle_stray_busy", busy, 0);
      // LW minimum latency
      issue(0, 0, 3'b010, 32'h100, 32'd0, 5'd5);
      chk("lw_bus_req", bus_req, 1);
      chk("lw_bus_addr", bus_addr, 32'h100);
      chk("lw_bus_be", bus_be, 4'b1111);
      chk("lw_bus_we", bus_we, 0);
      chk("lw_busy", busy, 1);
      chk("lw_not_ready", req_ready, 0);
      fast(32'hDEADBEEF);
      chk("lw_resp_valid", resp_valid, 1);
      chk("lw_resp_data", resp_data, 32'hDEADBEEF);
      chk("lw_resp_we", resp_we, 1);
      chk("lw_resp_rd", resp_rd, 5);
      chk("lw_ready_c3", req_ready, 0);
      @(negedge clk);
      chk("lw_ready_c4", req_ready, 1);
      chk("lw_resp_pulse", resp_valid, 0);
      // byte/half extraction
      load("lb", 3'b000, 32'h103, 32'h80123456, 32'hFFFFFF80);
      load("lbu", 3'b100, 32'h103, 32'h80123456, 32'h00000080);
      load("lhu", 3'b101, 32'h102, 32'h80123456, 32'h00008012);
      load("lh", 3'b001, 32'h102, 32'h80123456, 32'hFFFF8012);
      load("lb0", 3'b000, 32'h100, 32'h80123456, 32'h00000056);
      // SB lane steering
      issue(0, 1, 3'b000, 32'h201, 32'h000000AB, 5'd3);
      chk("sb_we", bus_we, 1);
      chk("sb_addr", bus_addr, 32'h200);
      chk("sb_be", bus_be, 4'b0010);
      chk("sb_wdata", bus_wdata, 32'hABABABAB);
      fast(32'h55555555);
      chk("sb_resp_valid", resp_valid, 1);
      chk("sb_resp_we", resp_we, 0);
      chk("sb_resp_data", resp_data, 0);
      @(negedge clk);
      // SH upper half
      issue(0, 1, 3'b001, 32'h202, 32'h1234CDEF, 5'd3);
      chk("sh_be", bus_be, 4'b1100);
      chk("sh_wdata", bus_wdata, 32'hCDEFCDEF);
      fast(32'd0);
      chk("sh_resp_valid", resp_valid, 1);
      @(negedge clk);
      // exceptions
      exc_case("sh_mis", 1, 3'b001, 32'h301, 4'd6);
      exc_case("lw_mis", 0, 3'b010, 32'h302, 4'd4);
      exc_case("ld_ill", 0, 3'b011, 32'h300, 4'd2);
      exc_case("st_ill", 1, 3'b100, 32'h300, 4'd2);
      // gnt withheld 3 cycles, rvalid 2 cycles after gnt, rd=0
      issue(0, 0, 3'b010, 32'h400, 32'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         chk("hold_req", bus_req, 1);
         chk("hold_addr", bus_addr, 32'h400);
         chk("hold_be", bus_be, 4'b1111);
         @(negedge clk);
      end
      chk("hold_req4", bus_req, 1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk("wait_req_low", bus_req, 0);
      chk("wait_busy", busy, 1);
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 32'h11223344;
      @(negedge clk);
      bus_rvalid = 1'b0;
      chk("wait_no_early", resp_valid, 0);
      @(negedge clk);
      chk("wait_resp_valid", resp_valid, 1);
      chk("wait_resp_data", resp_data, 32'h11223344);
      chk("rd0_resp_we", resp_we, 0);
      @(negedge clk);
      chk("wait_single_resp", resp_valid, 0);
      // load timeout on TIMEOUT=4 instance
      issue(1, 0, 3'b010, 32'h500, 32'd0, 5'd1);
      repeat (3) @(negedge clk);
      chk("lto_req_c4", t_bus_req, 1);
      chk("lto_no_exc_c4", t_exc_valid, 0);
      @(negedge clk);
      chk("lto_exc", t_exc_valid, 1);
      chk("lto_cause", t_exc_cause, 5);
      chk("lto_addr", t_exc_addr, 32'h500);
      chk("lto_req_low", t_bus_req, 0);
      @(negedge clk);
      chk("lto_pulse", t_exc_valid, 0);
      chk("lto_no_resp", t_resp_valid, 0);
      @(negedge clk);
      // store timeout after gnt (WAIT path)
      issue(1, 1, 3'b010, 32'h504, 32'h0BADF00D, 5'd0);
      t_gnt = 1'b1;
      @(negedge clk);
      t_gnt = 1'b0;
      chk("sto_req_low", t_bus_req, 0);
      repeat (2) @(negedge clk);
      chk("sto_no_exc_c4", t_exc_valid, 0);
      @(negedge clk);
      chk("sto_exc", t_exc_valid, 1);
      chk("sto_cause", t_exc_cause, 7);
      chk("sto_addr", t_exc_addr, 32'h504);
      repeat (2) @(negedge clk);
      // reset during WAIT, then a stray rvalid
      issue(1, 0, 3'b010, 32'h600, 32'd0, 5'd7);
      t_gnt = 1'b1;
      @(negedge clk);
      t_gnt = 1'b0;
      chk("rstw_busy", t_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstw_idle", t_busy, 0);
      chk("rstw_ready", t_req_ready, 1);
      chk("rstw_req", t_bus_req, 0);
      t_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      t_rvalid = 1'b0;
      chk("rstw_stray1", t_resp_valid, 0);
      @(negedge clk);
      chk("rstw_stray2", t_resp_valid, 0);
      chk("rstw_busy2", t_busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
